// File: rtl/inverter_sequencer.sv
// inverter_sequencer: soft-start, gating and over-voltage trip sequencer.
// Optional auto-retry: define INVERTER_SEQ_AUTO_RETRY_EN.
module inverter_sequencer #(
    parameter int AW            = 12,
    parameter int RAMP_STEP     = 1,
    parameter int OV_LIMIT      = 1920,
    parameter int OV_CNT        = 4,
    parameter int RETRY_TICKS   = 100000,
    parameter int RUN_CLR_TICKS = 100000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 enable,
    input  logic                 clear_fault,
    input  logic signed [AW-1:0] amp_target,
    input  logic signed [AW-1:0] volt_fb,
    output logic signed [AW-1:0] amp_out,
    output logic                 ctrl_rst,
    output logic                 bridge_en,
    output logic                 fault,
    output logic                 ready,
    output logic [1:0]           state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RAMP  = 2'd1,
        S_RUN   = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    localparam logic signed [AW:0] STEP    = (AW+1)'(RAMP_STEP);
    localparam logic signed [AW:0] LIMIT   = (AW+1)'(OV_LIMIT);
    localparam logic [7:0]         CNT_MAX = 8'(OV_CNT);

    if (RAMP_STEP < 1 || OV_CNT < 1 || OV_CNT > 255 ||
        RETRY_TICKS < 1 || RUN_CLR_TICKS < 1) begin : g_bad_cfg
        $error("inverter_sequencer: illegal parameter set");
    end

    state_t                st_q, st_d;
    logic signed [AW-1:0]  amp_d;
    logic [7:0]            ov_q, ov_d, ov_inc;
    logic signed [AW:0]    tgt, amp_w, fb_w, fb_abs;
    logic signed [AW:0]    up, dn, step_v;
    logic                  over, trip;

`ifdef INVERTER_SEQ_AUTO_RETRY_EN
    localparam int RTW = $clog2(RETRY_TICKS + 1);
    localparam int RCW = $clog2(RUN_CLR_TICKS + 1);
    localparam logic [RTW-1:0] RT_LAST = RTW'(RETRY_TICKS - 1);
    localparam logic [RCW-1:0] RC_LAST = RCW'(RUN_CLR_TICKS - 1);
    localparam logic [RCW-1:0] RC_MAX  = RCW'(RUN_CLR_TICKS);

    logic [RTW-1:0] rt_q, rt_d;
    logic [RCW-1:0] rc_q, rc_d;
    logic [1:0]     nr_q, nr_d;
`endif

    // Target clamp, |fb| and saturating ramp step, all in AW+1 bits
    always_comb begin
        tgt    = amp_target[AW-1] ? '0 : {1'b0, amp_target};
        amp_w  = {amp_out[AW-1], amp_out};
        fb_w   = {volt_fb[AW-1], volt_fb};
        fb_abs = fb_w[AW] ? -fb_w : fb_w;
        over   = fb_abs > LIMIT;
        ov_inc = (ov_q == CNT_MAX) ? ov_q : ov_q + 8'd1;
        up     = amp_w + STEP;
        dn     = amp_w - STEP;
        if (amp_w < tgt)
            step_v = (up > tgt) ? tgt : up;
        else if (amp_w > tgt)
            step_v = (dn < tgt) ? tgt : dn;
        else
            step_v = amp_w;
    end

    // Next state: OV trip beats enable drop beats ramp/run update
    always_comb begin
        st_d  = st_q;
        amp_d = amp_out;
        ov_d  = ov_q;
        trip  = 1'b0;
`ifdef INVERTER_SEQ_AUTO_RETRY_EN
        rt_d  = (st_q == S_FAULT) ? rt_q : '0;
        rc_d  = (st_q == S_RUN) ? rc_q : '0;
        nr_d  = nr_q;
`endif
        unique case (st_q)
            S_IDLE: begin
                amp_d = '0;
                ov_d  = '0;
                if (enable)
                    st_d = S_RAMP;
            end
            S_RAMP, S_RUN: begin
                if (tick) begin
                    ov_d = over ? ov_inc : '0;
                    trip = over && (ov_inc == CNT_MAX);
                end
`ifdef INVERTER_SEQ_AUTO_RETRY_EN
                if (st_q == S_RUN && tick) begin
                    if (rc_q != RC_MAX)
                        rc_d = rc_q + 1'b1;
                    if (rc_q == RC_LAST || rc_q == RC_MAX)
                        nr_d = '0;
                end
`endif
                if (trip) begin
                    st_d  = S_FAULT;
                    amp_d = '0;
                end else if (!enable) begin
                    st_d  = S_IDLE;
                    amp_d = '0;
                    ov_d  = '0;
                end else if (st_q == S_RAMP) begin
                    if (tick) begin
                        amp_d = step_v[AW-1:0];
                        if (step_v == tgt)
                            st_d = S_RUN;
                    end
                end else if (tgt != amp_w) begin
                    st_d = S_RAMP;
                end
            end
            S_FAULT: begin
                amp_d = '0;
                if (clear_fault && !enable)
                    st_d = S_IDLE;
`ifdef INVERTER_SEQ_AUTO_RETRY_EN
                if (clear_fault && !enable) begin
                    nr_d = '0;
                end else if (tick && nr_q != 2'd3) begin
                    if (rt_q == RT_LAST) begin
                        st_d = S_IDLE;
                        nr_d = nr_q + 2'd1;
                    end else begin
                        rt_d = rt_q + 1'b1;
                    end
                end
`endif
            end
            default: st_d = S_IDLE;
        endcase
    end

    // State and registered outputs, all updated on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q      <= S_IDLE;
            amp_out   <= '0;
            ov_q      <= '0;
            ctrl_rst  <= 1'b1;
            bridge_en <= 1'b0;
            fault     <= 1'b0;
            ready     <= 1'b0;
        end else begin
            st_q      <= st_d;
            amp_out   <= amp_d;
            ov_q      <= ov_d;
            ctrl_rst  <= (st_d == S_IDLE) || (st_d == S_FAULT);
            bridge_en <= (st_d == S_RAMP) || (st_d == S_RUN);
            fault     <= (st_d == S_FAULT);
            ready     <= (st_d == S_RUN);
        end
    end

`ifdef INVERTER_SEQ_AUTO_RETRY_EN
    // Retry hold-off timer, RUN-time qualifier and retry budget
    always_ff @(posedge clk) begin
        if (rst) begin
            rt_q <= '0;
            rc_q <= '0;
            nr_q <= '0;
        end else begin
            rt_q <= rt_d;
            rc_q <= rc_d;
            nr_q <= nr_d;
        end
    end
`endif

    assign state = st_q;

endmodule

// File: tb/tb_inverter_sequencer.sv
// tb_inverter_sequencer: vector table, directed corner cases and
// randomized stimulus against a behavioural model of the sequencer.
module tb_inverter_sequencer;

    localparam int AW       = 12;
    localparam int STEP     = 1;
    localparam int OV_LIMIT = 1920;
    localparam int OV_CNT   = 4;
    localparam int RETRY    = 10;
    localparam int RUN_CLR  = 40;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 tick = 1'b0;
    logic                 enable = 1'b0;
    logic                 clear_fault = 1'b0;
    logic signed [AW-1:0] amp_target = '0;
    logic signed [AW-1:0] volt_fb = '0;
    logic signed [AW-1:0] amp_out;
    logic                 ctrl_rst, bridge_en, fault, ready;
    logic [1:0]           state;

    int checks = 0;
    int failures = 0;

    inverter_sequencer #(
        .AW(AW), .RAMP_STEP(STEP), .OV_LIMIT(OV_LIMIT), .OV_CNT(OV_CNT),
        .RETRY_TICKS(RETRY), .RUN_CLR_TICKS(RUN_CLR)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .enable(enable),
        .clear_fault(clear_fault), .amp_target(amp_target),
        .volt_fb(volt_fb), .amp_out(amp_out), .ctrl_rst(ctrl_rst),
        .bridge_en(bridge_en), .fault(fault), .ready(ready),
        .state(state)
    );

    always #5 clk = ~clk;

    // Behavioural reference: mode 0 idle, 1 ramp, 2 run, 3 fault
    int m_mode = 0, m_amp = 0, m_ov = 0;
    int m_retries = 0, m_hold = 0, m_runt = 0;

    always @(posedge clk) begin
        int t, a, d;
        bit tr;
        t = int'(amp_target);
        if (t < 0) t = 0;
        a = int'(volt_fb);
        if (a < 0) a = -a;
        if (rst) begin
            m_mode = 0; m_amp = 0; m_ov = 0;
            m_retries = 0; m_hold = 0; m_runt = 0;
        end else begin
            tr = 0;
            if (m_mode != 3) m_hold = 0;
            if (m_mode != 2) m_runt = 0;
            case (m_mode)
                0: if (enable) begin m_mode = 1; m_ov = 0; end
                1, 2: begin
                    if (tick) begin
                        if (a > OV_LIMIT) begin
                            if (m_ov < OV_CNT) m_ov = m_ov + 1;
                            tr = (m_ov == OV_CNT);
                        end else m_ov = 0;
                    end
`ifdef INVERTER_SEQ_AUTO_RETRY_EN
                    if (m_mode == 2 && tick) begin
                        if (m_runt < RUN_CLR) m_runt = m_runt + 1;
                        if (m_runt == RUN_CLR) m_retries = 0;
                    end
`endif
                    if (tr) begin
                        m_mode = 3; m_amp = 0;
                    end else if (!enable) begin
                        m_mode = 0; m_amp = 0; m_ov = 0;
                    end else if (m_mode == 1) begin
                        if (tick) begin
                            d = t - m_amp;
                            if (d > STEP) d = STEP;
                            if (d < -STEP) d = -STEP;
                            m_amp = m_amp + d;
                            if (m_amp == t) m_mode = 2;
                        end
                    end else if (t != m_amp) m_mode = 1;
                end
                default: begin
                    if (clear_fault && !enable) begin
                        m_mode = 0;
                        m_retries = 0;
                    end
`ifdef INVERTER_SEQ_AUTO_RETRY_EN
                    else if (tick && m_retries < 3) begin
                        m_hold = m_hold + 1;
                        if (m_hold == RETRY) begin
                            m_mode = 0;
                            m_retries = m_retries + 1;
                        end
                    end
`endif
                end
            endcase
        end
    end

    function automatic logic [17:0] exp_pack(int md, int amp);
        logic [1:0] s;
        s = 2'(md);
        return {s, 12'(amp), (md == 0 || md == 3), (md == 1 || md == 2),
                (md == 3), (md == 2)};
    endfunction

    function automatic logic [17:0] dut_pack();
        return {state, amp_out, ctrl_rst, bridge_en, fault, ready};
    endfunction

    task automatic check(string name, logic [17:0] got, logic [17:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got st=%0d amp=%0d crst/ben/flt/rdy=%b want st=%0d amp=%0d crst/ben/flt/rdy=%b t=%0t",
                     name, got[17:16], $signed(got[15:4]), got[3:0],
                     want[17:16], $signed(want[15:4]), want[3:0], $time);
        end
    endtask

    // One clock; outputs are compared to the model on the falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        check("model", dut_pack(), exp_pack(m_mode, m_amp));
    endtask

    task automatic expect_st(string name, int md, int amp);
        check(name, dut_pack(), exp_pack(md, amp));
    endtask

    task automatic do_ticks(int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1; step();
            tick = 1'b0; step();
        end
    endtask

    task automatic clear_pulse();
        enable = 1'b0; step();
        clear_fault = 1'b1; step();
        clear_fault = 1'b0;
    endtask

    typedef struct {
        logic        rst, en, tk, clr;
        logic [11:0] tgt, fb;
        logic [1:0]  st;
        logic [11:0] amp;
        logic        crst, ben, flt, rdy;
    } vec_t;

    vec_t tbl[14];

    initial begin
        tbl[0]  = '{1, 0, 0, 0, 12'd0,   12'd0,    2'd0, 12'd0, 1, 0, 0, 0};
        tbl[1]  = '{0, 1, 0, 0, 12'd3,   12'd0,    2'd1, 12'd0, 0, 1, 0, 0};
        tbl[2]  = '{0, 1, 1, 0, 12'd3,   12'd0,    2'd1, 12'd1, 0, 1, 0, 0};
        tbl[3]  = '{0, 1, 0, 0, 12'd3,   12'd0,    2'd1, 12'd1, 0, 1, 0, 0};
        tbl[4]  = '{0, 1, 1, 0, 12'd3,   12'd0,    2'd1, 12'd2, 0, 1, 0, 0};
        tbl[5]  = '{0, 1, 1, 0, 12'd3,   12'd0,    2'd2, 12'd3, 0, 1, 0, 1};
        tbl[6]  = '{0, 1, 1, 0, 12'd3,   12'd0,    2'd2, 12'd3, 0, 1, 0, 1};
        tbl[7]  = '{0, 1, 0, 0, 12'd2,   12'd0,    2'd1, 12'd3, 0, 1, 0, 0};
        tbl[8]  = '{0, 1, 1, 0, 12'd2,   12'd0,    2'd2, 12'd2, 0, 1, 0, 1};
        tbl[9]  = '{0, 1, 1, 0, 12'hF9C, 12'd0,    2'd1, 12'd2, 0, 1, 0, 0};
        tbl[10] = '{0, 1, 1, 0, 12'hF9C, 12'd0,    2'd1, 12'd1, 0, 1, 0, 0};
        tbl[11] = '{0, 1, 1, 0, 12'hF9C, 12'd0,    2'd2, 12'd0, 0, 1, 0, 1};
        tbl[12] = '{0, 0, 0, 0, 12'hF9C, 12'd0,    2'd0, 12'd0, 1, 0, 0, 0};
        tbl[13] = '{0, 0, 1, 1, 12'd0,   12'd2000, 2'd0, 12'd0, 1, 0, 0, 0};

        for (int i = 0; i < 14; i++) begin
            rst = tbl[i].rst; enable = tbl[i].en; tick = tbl[i].tk;
            clear_fault = tbl[i].clr;
            amp_target = tbl[i].tgt; volt_fb = tbl[i].fb;
            step();
            check($sformatf("tbl%0d", i), dut_pack(),
                  {tbl[i].st, tbl[i].amp, tbl[i].crst, tbl[i].ben,
                   tbl[i].flt, tbl[i].rdy});
        end
        tick = 0; clear_fault = 0; volt_fb = '0;

        // Soft start to 1280
        rst = 1; step(); rst = 0;
        enable = 1; amp_target = 12'sd1280; step();
        expect_st("ss_enter", 1, 0);
        do_ticks(1279);
        expect_st("ss_1279", 1, 1279);
        tick = 1; step(); tick = 0;
        expect_st("ss_run", 2, 1280);

        // Retarget down, then negative target clamps to 0
        amp_target = 12'sd640; step();
        expect_st("rt_enter", 1, 1280);
        do_ticks(639);
        expect_st("rt_641", 1, 641);
        do_ticks(1);
        expect_st("rt_run", 2, 640);
        amp_target = -12'sd100; step();
        expect_st("neg_enter", 1, 640);
        do_ticks(640);
        expect_st("neg_run", 2, 0);

        // Over-voltage filter: 3 ticks no trip, 4 ticks trip
        volt_fb = 12'sd2000; do_ticks(3);
        volt_fb = 12'sd0; do_ticks(1);
        expect_st("ov_3", 2, 0);
        volt_fb = 12'sd2000; do_ticks(3);
        expect_st("ov_pre", 2, 0);
        tick = 1; step(); tick = 0;
        expect_st("ov_trip", 3, 0);
        volt_fb = 12'sd0;

        // Fault clear with and without enable
        clear_fault = 1; step(); clear_fault = 0;
        expect_st("clr_en", 3, 0);
        clear_pulse();
        expect_st("clr_ok", 0, 0);

        // -2048 is over the limit
        enable = 1; step();
        expect_st("neg_ramp", 1, 0);
        volt_fb = 12'h800; do_ticks(4);
        expect_st("ov_neg", 3, 0);
        volt_fb = 12'sd0; clear_pulse();

        // Trip and enable drop on the same edge
        enable = 1; step();
        volt_fb = 12'sd2000; do_ticks(3);
        tick = 1; enable = 0; step(); tick = 0;
        expect_st("coll", 3, 0);
        volt_fb = 12'sd0; clear_pulse();

        // Reset in the middle of a ramp
        enable = 1; amp_target = 12'sd1000; step();
        do_ticks(5);
        expect_st("mid_ramp", 1, 5);
        rst = 1; tick = 1; step(); rst = 0; tick = 0;
        expect_st("mid_rst", 0, 0);
        enable = 0; step();

`ifdef INVERTER_SEQ_AUTO_RETRY_EN
        // Three automatic retries, fourth trip latches
        amp_target = '0; enable = 1; step();
        for (int k = 1; k <= 4; k++) begin
            volt_fb = 12'sd2000; do_ticks(4);
            volt_fb = 12'sd0;
            expect_st($sformatf("rty_trip%0d", k), 3, 0);
            if (k < 4) begin
                do_ticks(9);
                expect_st("rty_hold", 3, 0);
                tick = 1; step(); tick = 0;
                expect_st("rty_idle", 0, 0);
                step();
                expect_st("rty_ramp", 1, 0);
            end else begin
                do_ticks(20);
                expect_st("rty_latch", 3, 0);
            end
        end
        clear_pulse();
        expect_st("rty_clr", 0, 0);
`endif

        // Randomized traffic checked only against the model
        enable = 1;
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 399) == 0);
            tick = ($urandom_range(0, 9) < 3);
            clear_fault = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 49) == 0) enable = ~enable;
            if ($urandom_range(0, 29) == 0)
                amp_target = ($urandom_range(0, 4) == 0) ? -12'sd50
                           : 12'($urandom_range(0, 40));
            if ($urandom_range(0, 9) < 3) begin
                if ($urandom_range(0, 1) == 1)
                    volt_fb = 12'($urandom_range(1921, 2047));
                else
                    volt_fb = 12'(-int'($urandom_range(1921, 2048)));
            end else begin
                volt_fb = 12'(int'($urandom_range(0, 3840)) - 1920);
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
